// File: rtl/fifo72_rx_parser.sv
// fifo72_rx_parser
// Reads lane-0-aligned 72-bit XGMII words from a standard (non-FWFT) RX FIFO.
// Strips preamble/SFD, finds the terminate lane, and emits a framed byte
// stream with sop/eop, a byte-keep mask, the frame length and an error flag.
//
// Build option: define RX_STATS_EN to implement the stat_frames/stat_errors
// wrapping counters. When it is not defined, both ports are tied to 0.
//
// Handshake: rd_en is a read request. dout is meaningful only in the cycle
// after rd_en (tracked by in_vld_q). out_valid is a single-cycle strobe with
// no ready, so the sink must accept every beat it is offered.
`timescale 1ns/1ps
module fifo72_rx_parser #(
  parameter logic [15:0] MIN_LEN = 16'd64,
  parameter logic [15:0] MAX_LEN = 16'd1518
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        empty,
  input  logic [71:0] dout,
  output logic        rd_en,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic [7:0]  out_keep,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  output logic [15:0] out_len,
  output logic [31:0] stat_frames,
  output logic [31:0] stat_errors,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_DROP  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  // Registered state
  state_t      state_q, state_d;
  logic        in_vld_q, in_vld_d;
  logic [63:0] hold_data_q, hold_data_d;
  logic [7:0]  hold_keep_q, hold_keep_d;
  logic        hold_sop_q, hold_sop_d;
  logic        hold_full_q, hold_full_d;
  logic        first_q, first_d;
  logic [15:0] len_q, len_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;
  logic [7:0]  out_keep_q, out_keep_d;
  logic        out_sop_q, out_sop_d;
  logic        out_eop_q, out_eop_d;
  logic        out_err_q, out_err_d;
  logic [15:0] out_len_q, out_len_d;

  // Word classification
  logic [7:0]  ctrl;
  logic        is_start;
  logic        pre_ok;
  logic        is_idle;
  logic        is_data;
  logic        is_term;
  logic [2:0]  term_lane;

  // Per-cycle actions
  logic        emit;
  logic        emit_eop;
  logic        emit_abort;
  logic        load;
  logic [7:0]  load_keep;
  logic        take_start;
  logic        drop_exit;
  logic        silent_end;
  logic        frame_end;
  logic        err_end;

  // Length accumulation saturates rather than wrapping.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hffff : s[15:0];
  endfunction

  // The FIFO is read whenever it has data and the block is out of reset.
  assign rd_en = !empty && !sys_rst;

  // Classify the word presented by the FIFO this cycle.
  always_comb begin
    ctrl      = dout[71:64];
    is_start  = (ctrl == 8'h01) && (dout[7:0] == 8'hFB);
    pre_ok    = (dout[63:8] == 56'hD5_55_55_55_55_55_55);
    is_idle   = ctrl[0] && (dout[7:0] == 8'h07);
    is_data   = (ctrl == 8'h00);
    term_lane = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (ctrl[i]) term_lane = 3'(i);
    end
    is_term   = (ctrl != 8'h00) && (dout[{term_lane, 3'b000} +: 8] == 8'hFD);
  end

  // Next-state, hold register and output-beat computation.
  always_comb begin
    state_d     = state_q;
    in_vld_d    = rd_en;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    hold_sop_d  = hold_sop_q;
    hold_full_d = hold_full_q;
    first_d     = first_q;
    len_d       = len_q;
    emit        = 1'b0;
    emit_eop    = 1'b0;
    emit_abort  = 1'b0;
    load        = 1'b0;
    load_keep   = 8'hff;
    take_start  = 1'b0;
    drop_exit   = 1'b0;
    silent_end  = 1'b0;

    case (state_q)
      S_IDLE: begin
        take_start = in_vld_q && is_start;
      end
      S_DATA: begin
        if (in_vld_q) begin
          if (is_data) begin
            emit  = hold_full_q;
            load  = 1'b1;
            len_d = sat_add(len_q, 4'd8);
          end else if (is_term && (term_lane == 3'd0)) begin
            // Terminate in lane 0: the held word is the last beat.
            if (hold_full_q) begin
              emit     = 1'b1;
              emit_eop = 1'b1;
            end else begin
              silent_end = 1'b1;
            end
            hold_full_d = 1'b0;
            state_d     = S_IDLE;
          end else if (is_term) begin
            // Partial last word: park it and finish it in FLUSH.
            emit      = hold_full_q;
            load      = 1'b1;
            load_keep = (8'h01 << term_lane) - 8'h01;
            len_d     = sat_add(len_q, {1'b0, term_lane});
            state_d   = S_FLUSH;
          end else begin
            // IDLE, START or bad control inside a frame aborts it.
            if (hold_full_q) begin
              emit       = 1'b1;
              emit_eop   = 1'b1;
              emit_abort = 1'b1;
            end else begin
              silent_end = 1'b1;
            end
            hold_full_d = 1'b0;
            state_d     = S_IDLE;
            take_start  = is_start;
          end
        end
      end
      S_FLUSH: begin
        emit        = 1'b1;
        emit_eop    = 1'b1;
        hold_full_d = 1'b0;
        state_d     = S_IDLE;
        take_start  = in_vld_q && is_start;
      end
      S_DROP: begin
        if (in_vld_q && (is_term || is_idle)) begin
          drop_exit = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      hold_data_d = dout[63:0];
      hold_keep_d = load_keep;
      hold_sop_d  = first_q;
      first_d     = 1'b0;
      hold_full_d = 1'b1;
    end

    if (take_start) begin
      state_d     = pre_ok ? S_DATA : S_DROP;
      first_d     = 1'b1;
      len_d       = 16'd0;
      hold_full_d = 1'b0;
    end

    out_valid_d = emit;
    out_sop_d   = emit && hold_sop_q;
    out_eop_d   = emit && emit_eop;
    out_err_d   = emit && emit_eop &&
                  (emit_abort || (len_q < MIN_LEN) || (len_q > MAX_LEN));
    out_data_d  = emit ? hold_data_q : out_data_q;
    out_keep_d  = emit ? hold_keep_q : out_keep_q;
    out_len_d   = (emit && emit_eop) ? len_q : out_len_q;

    // A frame ends on an eop beat, on leaving DROP, or when it closes empty.
    frame_end = out_eop_d || drop_exit || silent_end;
    err_end   = out_err_d || drop_exit || silent_end;
  end

  // Single state/output register bank with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      in_vld_q    <= 1'b0;
      hold_data_q <= 64'd0;
      hold_keep_q <= 8'd0;
      hold_sop_q  <= 1'b0;
      hold_full_q <= 1'b0;
      first_q     <= 1'b0;
      len_q       <= 16'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 64'd0;
      out_keep_q  <= 8'd0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_len_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      in_vld_q    <= in_vld_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      hold_sop_q  <= hold_sop_d;
      hold_full_q <= hold_full_d;
      first_q     <= first_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_err_q   <= out_err_d;
      out_len_q   <= out_len_d;
    end
  end

`ifdef RX_STATS_EN
  logic [31:0] stat_frames_q, stat_frames_d;
  logic [31:0] stat_errors_q, stat_errors_d;

  // Frame and error counters advance together with the eop beat or DROP exit.
  always_comb begin
    stat_frames_d = stat_frames_q + (frame_end ? 32'd1 : 32'd0);
    stat_errors_d = stat_errors_q + (err_end ? 32'd1 : 32'd0);
  end

  // Counter registers, wrapping.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stat_frames_q <= 32'd0;
      stat_errors_q <= 32'd0;
    end else begin
      stat_frames_q <= stat_frames_d;
      stat_errors_q <= stat_errors_d;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_errors = stat_errors_q;
`else
  logic stats_unused;
  assign stats_unused = ^{frame_end, err_end};
  assign stat_frames  = 32'd0;
  assign stat_errors  = 32'd0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_err   = out_err_q;
  assign out_len   = out_len_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo72_rx_parser.sv
// Bench for fifo72_rx_parser: emulates a standard RX FIFO, keeps a
// frame-level byte model with an expected-beat queue, and compares every
// output beat against it.
`timescale 1ns/1ps
module tb_fifo72_rx_parser;

  // ---------------- clock / reset ----------------
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        empty = 1'b1;
  logic [71:0] dout = '0;
  logic        rd_en;
  logic        out_valid;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic        out_sop;
  logic        out_eop;
  logic        out_err;
  logic [15:0] out_len;
  logic [31:0] stat_frames;
  logic [31:0] stat_errors;
  logic [1:0]  dbg_state;

  always #5 sys_clk = ~sys_clk;

  fifo72_rx_parser dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .empty       (empty),
    .dout        (dout),
    .rd_en       (rd_en),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_keep    (out_keep),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_err     (out_err),
    .out_len     (out_len),
    .stat_frames (stat_frames),
    .stat_errors (stat_errors),
    .dbg_state   (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- FIFO emulation (non-FWFT) ----------------
  logic [71:0] fifo_q[$];
  bit          stall_en = 1'b0;

  always @(posedge sys_clk) begin
    if (rd_en && (fifo_q.size() > 0)) dout <= fifo_q.pop_front();
  end

  always @(negedge sys_clk) begin
    empty = (fifo_q.size() == 0) || (stall_en && ($urandom_range(0, 2) == 0));
  end

  // ---------------- behavioural model ----------------
  // Expected beat: {sop, eop, err, len[15:0], keep[7:0], data[63:0]}
  logic [90:0] exp_q[$];
  logic [7:0]  fb[$];
  int          m_mode = 0;      // 0 idle, 1 in frame, 2 discarding
  int          exp_frames = 0;
  int          exp_errors = 0;

  function automatic int lowest_ctrl(input logic [7:0] c);
    for (int i = 0; i < 8; i++) if (c[i]) return i;
    return 8;
  endfunction

  task automatic model_end(input bit abort);
    int          n;
    logic [15:0] len;
    bit          err;
    n   = fb.size();
    len = (n > 65535) ? 16'hffff : 16'(n);
    err = abort || (n < 64) || (n > 1518);
    exp_frames++;
    if (err) exp_errors++;
    for (int b = 0; b * 8 < n; b++) begin
      logic [63:0] d;
      logic [7:0]  k;
      bit          last;
      d    = '0;
      k    = '0;
      last = (b * 8 + 8 >= n);
      for (int j = 0; j < 8; j++) begin
        if (b * 8 + j < n) begin
          d[j*8 +: 8] = fb[b*8 + j];
          k[j]        = 1'b1;
        end
      end
      exp_q.push_back({(b == 0), last, last & err, (last ? len : 16'h0), k, d});
    end
    fb.delete();
  endtask

  task automatic model_word(input logic [71:0] w);
    logic [7:0] c;
    int         k;
    bit         st, pre, idl, dat, trm;
    c   = w[71:64];
    k   = lowest_ctrl(c);
    st  = (c == 8'h01) && (w[7:0] == 8'hFB);
    pre = (w[63:8] == {8'hD5, {6{8'h55}}});
    idl = c[0] && (w[7:0] == 8'h07);
    dat = (c == 8'h00);
    trm = 1'b0;
    if (k < 8) trm = (w[k*8 +: 8] == 8'hFD);
    case (m_mode)
      0: if (st) begin m_mode = pre ? 1 : 2; fb.delete(); end
      1: begin
        if (dat) begin
          for (int j = 0; j < 8; j++) fb.push_back(w[j*8 +: 8]);
        end else if (trm) begin
          for (int j = 0; j < k; j++) fb.push_back(w[j*8 +: 8]);
          model_end(1'b0);
          m_mode = 0;
        end else begin
          model_end(1'b1);
          m_mode = 0;
          if (st) begin m_mode = pre ? 1 : 2; fb.delete(); end
        end
      end
      default: if (trm || idl) begin exp_frames++; exp_errors++; m_mode = 0; end
    endcase
  endtask

  // ---------------- scoreboard / compare ----------------
  int          beat_cnt = 0;
  logic [7:0]  last_keep = '0;
  logic [15:0] last_len = '0;
  logic        last_err = 1'b0;

  always @(negedge sys_clk) begin
    if (out_valid) begin
      logic [90:0] e;
      logic [63:0] m;
      beat_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: unexpected beat data=%h keep=%h sop=%0b eop=%0b, none expected",
                 out_data, out_keep, out_sop, out_eop);
      end else begin
        e = exp_q.pop_front();
        m = '0;
        for (int j = 0; j < 8; j++) if (e[64 + j]) m[j*8 +: 8] = 8'hff;
        if (((out_data & m) !== e[63:0]) || (out_keep !== e[71:64]) ||
            (out_sop !== e[90]) || (out_eop !== e[89]) || (out_err !== e[88]) ||
            (out_eop && (out_len !== e[87:72]))) begin
          errors++;
          $display("FAIL beat: got data=%h keep=%h sop=%0b eop=%0b err=%0b len=%0d, expected data=%h keep=%h sop=%0b eop=%0b err=%0b len=%0d",
                   out_data & m, out_keep, out_sop, out_eop, out_err, out_len,
                   e[63:0], e[71:64], e[90], e[89], e[88], e[87:72]);
        end
      end
      if (out_eop) begin
        last_keep = out_keep;
        last_len  = out_len;
        last_err  = out_err;
      end
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  logic [7:0] dbyte = 8'h10;

  function automatic logic [71:0] w_start();
    return {8'h01, 8'hD5, {6{8'h55}}, 8'hFB};
  endfunction

  function automatic logic [71:0] w_idle();
    return {8'hff, {8{8'h07}}};
  endfunction

  task automatic send(input logic [71:0] w);
    model_word(w);
    fifo_q.push_back(w);
  endtask

  task automatic send_data(input int n);
    logic [71:0] w;
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int j = 0; j < 8; j++) w[j*8 +: 8] = dbyte + 8'(j);
      dbyte = dbyte + 8'd8;
      send(w);
    end
  endtask

  task automatic send_term(input int k);
    logic [71:0] w;
    w = '0;
    w[71:64] = 8'hff << k;
    for (int j = 0; j < 8; j++) begin
      if (j < k)       w[j*8 +: 8] = dbyte + 8'(j);
      else if (j == k) w[j*8 +: 8] = 8'hFD;
      else             w[j*8 +: 8] = 8'h07;
    end
    dbyte = dbyte + 8'd8;
    send(w);
  endtask

  task automatic drain();
    int n;
    longint sf, se;
    n = 0;
    while ((fifo_q.size() != 0) && (n < 20000)) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (8) @(negedge sys_clk);
    check("drain_bound", (n < 20000), 1);
    check("exp_queue_empty", exp_q.size(), 0);
`ifdef RX_STATS_EN
    sf = exp_frames;
    se = exp_errors;
`else
    sf = 0;
    se = 0;
`endif
    check("stat_frames", stat_frames, sf);
    check("stat_errors", stat_errors, se);
  endtask

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_flags"}, {out_sop, out_eop, out_err}, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_keep"}, out_keep, 0);
    check({tag, "_len"}, out_len, 0);
    check({tag, "_stat_frames"}, stat_frames, 0);
    check({tag, "_stat_errors"}, stat_errors, 0);
    check({tag, "_rd_en"}, rd_en, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (4) @(negedge sys_clk);
    reset_outputs_zero("reset");
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Good frame: 8 data + TERM(4) -> 9 beats, len 68
    beat_cnt = 0;
    send(w_start()); send_data(8); send_term(4); send(w_idle());
    drain();
    check("t1_beats", beat_cnt, 9);
    check("t1_keep", last_keep, 8'h0f);
    check("t1_len", last_len, 68);
    check("t1_err", last_err, 0);

    // Runt: 7 data + TERM(0) -> 7 beats, len 56, err
    beat_cnt = 0;
    send(w_start()); send_data(7); send_term(0); send(w_idle());
    drain();
    check("t2_beats", beat_cnt, 7);
    check("t2_keep", last_keep, 8'hff);
    check("t2_len", last_len, 56);
    check("t2_err", last_err, 1);

    // Bad preamble: nothing emitted
    beat_cnt = 0;
    begin
      logic [71:0] w;
      w = w_start();
      w[31:24] = 8'h00;
      send(w);
    end
    send_data(9); send_term(2); send(w_idle());
    drain();
    check("t3_beats", beat_cnt, 0);

    // Oversize: 200 data + TERM(0) -> len 1600, err
    beat_cnt = 0;
    send(w_start()); send_data(200); send_term(0); send(w_idle());
    drain();
    check("t4_beats", beat_cnt, 200);
    check("t4_len", last_len, 1600);
    check("t4_err", last_err, 1);

    // Mid-frame START aborts previous frame; new frame follows
    beat_cnt = 0;
    send(w_start()); send_data(3); send(w_start()); send_data(2); send_term(0); send(w_idle());
    drain();
    check("t5_beats", beat_cnt, 5);
    check("t5_len", last_len, 16);

    // TERM lane sweep with FIFO stalls
    stall_en = 1'b1;
    for (int k = 1; k < 8; k++) begin
      send(w_start()); send_data(8); send_term(k);
    end
    send(w_idle());
    drain();
    check("sweep_len", last_len, 71);

    // MIN boundary
    beat_cnt = 0;
    send(w_start()); send_data(8); send_term(0); send(w_idle());
    drain();
    check("min_ok_len", last_len, 64);
    check("min_ok_err", last_err, 0);
    send(w_start()); send_data(7); send_term(7); send(w_idle());
    drain();
    check("min_bad_len", last_len, 63);
    check("min_bad_err", last_err, 1);

    // MAX boundary
    send(w_start()); send_data(189); send_term(6); send(w_idle());
    drain();
    check("max_ok_len", last_len, 1518);
    check("max_ok_err", last_err, 0);
    send(w_start()); send_data(189); send_term(7); send(w_idle());
    drain();
    check("max_bad_len", last_len, 1519);
    check("max_bad_err", last_err, 1);

    // Aborts by IDLE and by bad control, back-to-back frames via FLUSH
    send(w_start()); send_data(10); send(w_idle());
    send(w_start()); send_data(9); send({8'h01, 56'h0, 8'h9C});
    send(w_start()); send_data(8); send_term(5);
    send(w_start()); send_data(9); send_term(0);
    begin
      logic [71:0] w;
      w = w_start();
      w[63:56] = 8'hD4;
      send(w_start()); send_data(4); send(w); send_data(3); send(w_idle());
    end
    drain();
    stall_en = 1'b0;

    // Reset mid-frame: no eop, everything back to zero
    beat_cnt = 0;
    send(w_start()); send_data(1);
    begin
      int n;
      n = 0;
      while ((fifo_q.size() != 0) && (n < 100)) begin @(negedge sys_clk); n++; end
    end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    reset_outputs_zero("midrst");
    m_mode = 0;
    fb.delete();
    exp_frames = 0;
    exp_errors = 0;
    sys_rst = 1'b0;
    send(w_idle()); send_data(2);
    send(w_start()); send_data(9); send_term(3); send(w_idle());
    drain();
    check("rst_beats", beat_cnt, 10);
    check("rst_len", last_len, 75);
    check("rst_err", last_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
